// File: rtl/test_mipi_unpacket_gen.sv
// rtl/test_mipi_unpacket_gen.sv - synthetic unpacked MIPI pixel stream frame generator
module test_mipi_unpacket_gen #(
    parameter int          Lane_Num   = 2,
    parameter int          Byte_w     = 8,
    parameter int          Lane_Width = Lane_Num * Byte_w,
    parameter int          Image_H    = 1080,
    parameter int          Image_W    = 1920,
    parameter int          H_Blank    = 16,
    parameter int          V_Sync_Len = 4,
    parameter int          V_Back     = 8,
    parameter int          V_Front    = 8,
    parameter logic [15:0] Const_Word = 16'hA55A
) (
    input  logic                  I_CLK,
    input  logic                  I_Rst_n,
    input  logic                  I_Enable,
    input  logic [15:0]           I_Frame_Num,
    input  logic [1:0]            I_Pattern,
    output logic [Lane_Width-1:0] O_Data,
    output logic                  O_Vaild,
    output logic                  O_V_sync,
    output logic                  O_Frame_Done,
    output logic [15:0]           O_Frame_Cnt,
    output logic                  O_Busy
);

    localparam int Words_Per_Line = Image_W * Byte_w / Lane_Width;
    localparam int Bar_Len        = Words_Per_Line / 8;

    localparam logic [15:0] C_VSYNC_LAST = 16'(V_Sync_Len - 1);
    localparam logic [15:0] C_VBACK_LAST = 16'(V_Back - 1);
    localparam logic [15:0] C_WORD_LAST  = 16'(Words_Per_Line - 1);
    localparam logic [15:0] C_LINE_LAST  = 16'(Image_H - 1);
    localparam logic [15:0] C_HBLK_LAST  = 16'(H_Blank - 1);
    localparam logic [15:0] C_VFRNT_LAST = 16'(V_Front - 1);
    localparam logic [15:0] C_BAR_LAST   = 16'(Bar_Len - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_VSYNC,
        S_VBACK,
        S_LINE,
        S_HBLANK,
        S_VFRONT
    } state_t;

    state_t      r_state;
    logic [15:0] r_cnt;
    logic [15:0] r_line;
    logic [15:0] r_bar_sub;
    logic [2:0]  r_bar;
    logic [1:0]  r_pattern;
    logic [15:0] r_frame_num;
    logic [15:0] r_frame_cnt;
    logic [Lane_Width-1:0] r_data;
    logic        r_valid;
    logic        r_vsync;
    logic        r_done;
    logic        r_busy;

    state_t      w_state_nxt;
    logic [15:0] w_cnt_nxt;
    logic [15:0] w_line_nxt;
    logic [15:0] w_bar_sub_nxt;
    logic [2:0]  w_bar_nxt;
    logic [1:0]  w_pattern_nxt;
    logic [15:0] w_frame_num_nxt;
    logic [15:0] w_frame_cnt_nxt;
    logic        w_done_nxt;
    logic [15:0] w_word;

    // Next state, position counters and the output values of the state being entered
    always_comb begin
        w_state_nxt     = r_state;
        w_cnt_nxt       = r_cnt + 16'd1;
        w_line_nxt      = r_line;
        w_bar_sub_nxt   = r_bar_sub;
        w_bar_nxt       = r_bar;
        w_pattern_nxt   = r_pattern;
        w_frame_num_nxt = r_frame_num;
        w_frame_cnt_nxt = r_frame_cnt;
        w_done_nxt      = 1'b0;
        w_word          = 16'd0;

        case (r_state)
            S_IDLE: begin
                w_cnt_nxt = 16'd0;
                if (I_Enable) begin
                    w_state_nxt     = S_VSYNC;
                    w_frame_cnt_nxt = 16'd0;
                    w_pattern_nxt   = I_Pattern;
                    w_frame_num_nxt = I_Frame_Num;
                end
            end
            S_VSYNC: begin
                if (r_cnt == C_VSYNC_LAST) begin
                    w_state_nxt = S_VBACK;
                    w_cnt_nxt   = 16'd0;
                end
            end
            S_VBACK: begin
                if (r_cnt == C_VBACK_LAST) begin
                    w_state_nxt   = S_LINE;
                    w_cnt_nxt     = 16'd0;
                    w_line_nxt    = 16'd0;
                    w_bar_sub_nxt = 16'd0;
                    w_bar_nxt     = 3'd0;
                end
            end
            S_LINE: begin
                if (r_cnt == C_WORD_LAST) begin
                    w_cnt_nxt   = 16'd0;
                    w_state_nxt = (r_line == C_LINE_LAST) ? S_VFRONT : S_HBLANK;
                end else if (r_bar_sub == C_BAR_LAST) begin
                    w_bar_sub_nxt = 16'd0;
                    w_bar_nxt     = r_bar + 3'd1;
                end else begin
                    w_bar_sub_nxt = r_bar_sub + 16'd1;
                end
            end
            S_HBLANK: begin
                if (r_cnt == C_HBLK_LAST) begin
                    w_state_nxt   = S_LINE;
                    w_cnt_nxt     = 16'd0;
                    w_line_nxt    = r_line + 16'd1;
                    w_bar_sub_nxt = 16'd0;
                    w_bar_nxt     = 3'd0;
                end
            end
            S_VFRONT: begin
                if (r_cnt == C_VFRNT_LAST) begin
                    w_cnt_nxt = 16'd0;
                    // r_frame_cnt already holds the count including this frame
                    if (I_Enable && ((r_frame_num == 16'd0) || (r_frame_cnt < r_frame_num))) begin
                        w_state_nxt   = S_VSYNC;
                        w_pattern_nxt = I_Pattern;
                    end else begin
                        w_state_nxt = S_IDLE;
                    end
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
                w_cnt_nxt   = 16'd0;
            end
        endcase

        // Last front-porch cycle: pulse done and count the frame in the same cycle
        if ((w_state_nxt == S_VFRONT) && (w_cnt_nxt == C_VFRNT_LAST)) begin
            w_done_nxt      = 1'b1;
            w_frame_cnt_nxt = r_frame_cnt + 16'd1;
        end

        if (w_state_nxt == S_LINE) begin
            case (r_pattern)
                2'd0:    w_word = w_cnt_nxt;
                2'd1:    w_word = {w_line_nxt[7:0], w_cnt_nxt[7:0]};
                2'd2:    w_word = Const_Word;
                default: w_word = {w_bar_nxt, 5'b0, w_bar_nxt, 5'b0};
            endcase
        end
    end

    // State, counters and registered outputs; asynchronous clear drops any partial frame
    always_ff @(posedge I_CLK or negedge I_Rst_n) begin
        if (!I_Rst_n) begin
            r_state     <= S_IDLE;
            r_cnt       <= 16'd0;
            r_line      <= 16'd0;
            r_bar_sub   <= 16'd0;
            r_bar       <= 3'd0;
            r_pattern   <= 2'd0;
            r_frame_num <= 16'd0;
            r_frame_cnt <= 16'd0;
            r_data      <= '0;
            r_valid     <= 1'b0;
            r_vsync     <= 1'b0;
            r_done      <= 1'b0;
            r_busy      <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_cnt       <= w_cnt_nxt;
            r_line      <= w_line_nxt;
            r_bar_sub   <= w_bar_sub_nxt;
            r_bar       <= w_bar_nxt;
            r_pattern   <= w_pattern_nxt;
            r_frame_num <= w_frame_num_nxt;
            r_frame_cnt <= w_frame_cnt_nxt;
            r_data      <= Lane_Width'(w_word);
            r_valid     <= (w_state_nxt == S_LINE);
            r_vsync     <= (w_state_nxt == S_VSYNC);
            r_done      <= w_done_nxt;
            r_busy      <= (w_state_nxt != S_IDLE);
        end
    end

    assign O_Data       = r_data;
    assign O_Vaild      = r_valid;
    assign O_V_sync     = r_vsync;
    assign O_Frame_Done = r_done;
    assign O_Frame_Cnt  = r_frame_cnt;
    assign O_Busy       = r_busy;

endmodule

// File: tb/tb_test_mipi_unpacket_gen.sv
// tb/tb_test_mipi_unpacket_gen.sv - scoreboard bench for test_mipi_unpacket_gen
module tb_test_mipi_unpacket_gen;

    localparam int IH  = 4;
    localparam int IW  = 16;
    localparam int HB  = 3;
    localparam int VS  = 2;
    localparam int VB  = 2;
    localparam int VF  = 2;
    localparam int WPL = IW * 8 / 16;

    logic        clk = 1'b0;
    logic        rstn = 1'b0;
    logic        en = 1'b0;
    logic [15:0] fnum = 16'd0;
    logic [1:0]  pat = 2'd0;
    logic [15:0] o_data;
    logic        o_valid;
    logic        o_vsync;
    logic        o_done;
    logic [15:0] o_fcnt;
    logic        o_busy;

    int n_chk  = 0;
    int n_fail = 0;

    typedef struct packed {
        logic        vs;
        logic        va;
        logic [15:0] d;
        logic        dn;
        logic [15:0] cnt;
    } rec_t;

    rec_t exp_q[$];

    test_mipi_unpacket_gen #(
        .Image_H(IH), .Image_W(IW), .H_Blank(HB),
        .V_Sync_Len(VS), .V_Back(VB), .V_Front(VF)
    ) dut (
        .I_CLK(clk),
        .I_Rst_n(rstn),
        .I_Enable(en),
        .I_Frame_Num(fnum),
        .I_Pattern(pat),
        .O_Data(o_data),
        .O_Vaild(o_valid),
        .O_V_sync(o_vsync),
        .O_Frame_Done(o_done),
        .O_Frame_Cnt(o_fcnt),
        .O_Busy(o_busy)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Pixel value for a given pattern, line and word position
    function automatic logic [15:0] ref_word(int p, int l, int x);
        logic [2:0] bar;
        case (p)
            0:       return 16'(x);
            1:       return {8'(l), 8'(x)};
            2:       return 16'hA55A;
            default: begin
                bar = 3'(x / (WPL / 8));
                return {bar, 5'b0, bar, 5'b0};
            end
        endcase
    endfunction

    // Expected per-cycle output of frame k (0-based since leaving IDLE) built from the frame layout
    task automatic push_frame(input int p, input int k);
        rec_t r;
        for (int i = 0; i < VS; i++) begin
            r = '0; r.vs = 1'b1; r.cnt = 16'(k); exp_q.push_back(r);
        end
        for (int i = 0; i < VB; i++) begin
            r = '0; r.cnt = 16'(k); exp_q.push_back(r);
        end
        for (int l = 0; l < IH; l++) begin
            for (int x = 0; x < WPL; x++) begin
                r = '0; r.va = 1'b1; r.d = ref_word(p, l, x); r.cnt = 16'(k);
                exp_q.push_back(r);
            end
            if (l < IH - 1) begin
                for (int i = 0; i < HB; i++) begin
                    r = '0; r.cnt = 16'(k); exp_q.push_back(r);
                end
            end
        end
        for (int i = 0; i < VF; i++) begin
            r = '0;
            if (i == VF - 1) begin
                r.dn = 1'b1; r.cnt = 16'(k + 1);
            end else begin
                r.cnt = 16'(k);
            end
            exp_q.push_back(r);
        end
    endtask

    // Monitor: every busy cycle consumes one expected record; idle cycles must be silent
    always @(negedge clk) begin
        rec_t a;
        rec_t e;
        if (rstn) begin
            a.vs = o_vsync; a.va = o_valid; a.d = o_data; a.dn = o_done; a.cnt = o_fcnt;
            n_chk++;
            if (o_busy) begin
                if (exp_q.size() == 0) begin
                    n_fail++;
                    $display("FAIL unexpected_busy: actual busy=1 vs=%0b va=%0b d=%h required busy=0", a.vs, a.va, a.d);
                end else begin
                    e = exp_q.pop_front();
                    if (a !== e)
                        begin
                            n_fail++;
                            $display("FAIL stream @%0t: actual vs=%0b va=%0b d=%h dn=%0b cnt=%0d required vs=%0b va=%0b d=%h dn=%0b cnt=%0d",
                                     $time, a.vs, a.va, a.d, a.dn, a.cnt, e.vs, e.va, e.d, e.dn, e.cnt);
                        end
                end
            end else if ({a.vs, a.va, a.d, a.dn} !== 19'd0) begin
                n_fail++;
                $display("FAIL idle_outputs @%0t: actual vs=%0b va=%0b d=%h dn=%0b required all 0", $time, a.vs, a.va, a.d, a.dn);
            end
        end
    end

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic wait_done();
        int i;
        for (i = 0; i < 200; i++) begin
            @(negedge clk);
            if (o_done) break;
        end
        n_chk++;
        if (i == 200) begin
            n_fail++;
            $display("FAIL wait_done: actual no O_Frame_Done within 200 cycles required pulse");
        end
        @(posedge clk);
        #1;
    endtask

    task automatic wait_idle();
        int i;
        for (i = 0; i < 1000; i++) begin
            @(negedge clk);
            if (exp_q.size() == 0 && !o_busy) break;
        end
        n_chk++;
        if (i == 1000) begin
            n_fail++;
            $display("FAIL wait_idle: actual busy=%0b pending=%0d required idle with 0 pending", o_busy, exp_q.size());
        end
        step(1);
    endtask

    task automatic check_zero(input string name);
        n_chk++;
        if ({o_data, o_valid, o_vsync, o_done, o_fcnt, o_busy} !== 36'd0) begin
            n_fail++;
            $display("FAIL %s: actual d=%h va=%0b vs=%0b dn=%0b cnt=%0d busy=%0b required all 0",
                     name, o_data, o_valid, o_vsync, o_done, o_fcnt, o_busy);
        end
    endtask

    initial begin
        int p [5];
        int ps;

        // Reset state
        step(3);
        check_zero("reset_state");
        rstn = 1'b1;
        step(2);

        // Single frame, pattern 0, enable pulsed for one cycle
        pat = 2'd0; fnum = 16'd1;
        push_frame(0, 0);
        en = 1'b1; step(1); en = 1'b0;
        wait_idle();

        // Two frames with enable held; inputs scrambled once frame 2 has latched
        ps = int'($urandom_range(0, 3));
        pat = 2'(ps); fnum = 16'd2;
        push_frame(ps, 0);
        push_frame(ps, 1);
        en = 1'b1; step(1);
        wait_done();
        en = 1'b0; pat = ~pat; fnum = 16'($urandom);
        wait_idle();

        // Continuous mode, per-frame pattern, enable dropped during line 1 of frame 5
        p[0] = 1; p[1] = 3; p[2] = 2;
        p[3] = int'($urandom_range(0, 3)); p[4] = int'($urandom_range(0, 3));
        for (int k = 0; k < 5; k++) push_frame(p[k], k);
        fnum = 16'd0; pat = 2'(p[0]);
        en = 1'b1; step(1);
        pat = 2'(p[1]);
        for (int k = 0; k < 4; k++) begin
            wait_done();
            if (k < 3) begin
                pat = 2'(p[k + 2]);
            end else begin
                pat = 2'($urandom);
                fnum = 16'($urandom);
                step(18);
                en = 1'b0;
            end
        end
        wait_idle();
        step(20);

        // Asynchronous reset during line 2, then a fresh frame from count 0
        pat = 2'd1; fnum = 16'd1;
        push_frame(1, 0);
        en = 1'b1; step(1); en = 1'b0;
        step(28);
        #1;
        rstn = 1'b0;
        #1;
        check_zero("async_reset_mid_line");
        exp_q.delete();
        @(posedge clk);
        #1;
        rstn = 1'b1;
        step(2);
        check_zero("after_reset_release");
        pat = 2'd2; fnum = 16'd1;
        push_frame(2, 0);
        en = 1'b1; step(1); en = 1'b0;
        wait_idle();
        step(5);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
